datapath_seq: RTL and testbench

- Parametrised, sequenced successor to the fixed 32x64 register-file / ALU / 256x64 RAM datapath.
- Accepts one operation at a time over a valid/ready handshake and runs it through fixed stages: operand read, ALU, memory, writeback.
- Reports the result and latched ALU status flags.
- Sits under the top level as the execution core a future instruction decoder will drive.

---
 rtl/datapath_pkg.sv | 37 +++
 rtl/alu_param.sv | 74 +++++++
 rtl/datapath_seq.sv | 170 +++++++++++++++++
 tb/tb_datapath_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_pkg
//  Description : Shared ALU function codes, status bit indices and the
//                sequencer state encoding for the datapath_seq core.
//  Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

  // ALU function-select codes
  localparam int unsigned FS_PASS_A = 0;
  localparam int unsigned FS_PASS_B = 1;
  localparam int unsigned FS_ADD    = 2;
  localparam int unsigned FS_SUB    = 3;
  localparam int unsigned FS_AND    = 4;
  localparam int unsigned FS_OR     = 5;
  localparam int unsigned FS_XOR    = 6;
  localparam int unsigned FS_NOT_A  = 7;
  localparam int unsigned FS_SHL    = 8;
  localparam int unsigned FS_SHR    = 9;

  // Bit positions inside the 4-bit status word {V,C,N,Z}
  localparam int unsigned ST_Z = 0;
  localparam int unsigned ST_N = 1;
  localparam int unsigned ST_C = 2;
  localparam int unsigned ST_V = 3;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2,
    S_WB   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_param.sv
`default_nettype none
// ============================================================================
//  Module      : alu_param
//  Description : Combinational parametrised ALU producing a result and the
//                {V,C,N,Z} status flags. Unknown function codes yield zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_param
  import datapath_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int FS_W   = 5
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [FS_W-1:0]   fs_i,
  input  logic              cin_i,
  output logic [DATA_W-1:0] result_o,
  output logic [3:0]        status_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0]   add_sum_d;
  logic [DATA_W:0]   sub_sum_d;
  logic [DATA_W-1:0] res_d;
  logic              carry_d;
  logic              ovf_d;

  // Function decode; SUB is A + ~B + 1 so its carry-out means "no borrow"
  always_comb begin
    add_sum_d = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin_i};
    sub_sum_d = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_W{1'b0}}, 1'b1};
    res_d     = '0;
    carry_d   = 1'b0;
    ovf_d     = 1'b0;
    case (32'(fs_i))
      FS_PASS_A: res_d = a_i;
      FS_PASS_B: res_d = b_i;
      FS_ADD: begin
        res_d   = add_sum_d[DATA_W-1:0];
        carry_d = add_sum_d[DATA_W];
        ovf_d   = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                  (add_sum_d[DATA_W-1] != a_i[DATA_W-1]);
      end
      FS_SUB: begin
        res_d   = sub_sum_d[DATA_W-1:0];
        carry_d = sub_sum_d[DATA_W];
        ovf_d   = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                  (sub_sum_d[DATA_W-1] != a_i[DATA_W-1]);
      end
      FS_AND:   res_d = a_i & b_i;
      FS_OR:    res_d = a_i | b_i;
      FS_XOR:   res_d = a_i ^ b_i;
      FS_NOT_A: res_d = ~a_i;
      FS_SHL:   res_d = a_i << b_i[SH_W-1:0];
      FS_SHR:   res_d = a_i >> b_i[SH_W-1:0];
      default:  res_d = '0;
    endcase
  end

  // Flag assembly
  always_comb begin
    status_o       = '0;
    status_o[ST_Z] = (res_d == '0);
    status_o[ST_N] = res_d[DATA_W-1];
    status_o[ST_C] = carry_d;
    status_o[ST_V] = ovf_d;
  end

  assign result_o = res_d;

endmodule
`default_nettype wire

// File: rtl/datapath_seq.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_seq
//  Description : Sequenced register-file / ALU / data-RAM execution core.
//                One operation per handshake, stepped IDLE->EXEC->MEM->WB.
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int NREG      = 32,
  parameter int RAM_DEPTH = 256,
  parameter int FS_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [$clog2(NREG)-1:0] op_sel_a,
  input  logic [$clog2(NREG)-1:0] op_sel_b,
  input  logic [$clog2(NREG)-1:0] op_sel_d,
  input  logic [FS_W-1:0]         op_fs,
  input  logic                    op_cin,
  input  logic                    op_b_imm,
  input  logic [DATA_W-1:0]       op_imm,
  input  logic                    op_reg_we,
  input  logic                    op_ram_we,
  input  logic                    op_wb_sel,
  output logic                    res_valid,
  output logic [DATA_W-1:0]       res_data,
  output logic [3:0]              res_status
);

  localparam int SEL_W = $clog2(NREG);
  localparam int AW    = $clog2(RAM_DEPTH);

  state_t            state_q;
  logic              op_ready_q;
  logic [SEL_W-1:0]  sel_a_q;
  logic [SEL_W-1:0]  sel_b_q;
  logic [SEL_W-1:0]  sel_d_q;
  logic [FS_W-1:0]   fs_q;
  logic              cin_q;
  logic              b_imm_q;
  logic [DATA_W-1:0] imm_q;
  logic              reg_we_q;
  logic              ram_we_q;
  logic              wb_sel_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] res_data_q;
  logic [3:0]        res_status_q;
  logic              res_valid_q;

  logic [DATA_W-1:0] rf_q  [NREG];
  logic [DATA_W-1:0] ram_q [RAM_DEPTH];

  logic [DATA_W-1:0] opa_d;
  logic [DATA_W-1:0] opb_d;
  logic [DATA_W-1:0] alu_res_d;
  logic [3:0]        alu_status_d;
  logic [AW-1:0]     ram_addr_d;
  logic [DATA_W-1:0] wb_data_d;

  // Operand selection from the latched operation
  assign opa_d      = rf_q[sel_a_q];
  assign opb_d      = b_imm_q ? imm_q : rf_q[sel_b_q];
  // Only the low address bits are used, so large results wrap
  assign ram_addr_d = result_q[AW-1:0];
  // RAM is sampled before the same-edge store lands: read-first behaviour
  assign wb_data_d  = wb_sel_q ? ram_q[ram_addr_d] : result_q;

  alu_param #(
    .DATA_W (DATA_W),
    .FS_W   (FS_W)
  ) u_alu (
    .a_i      (opa_d),
    .b_i      (opb_d),
    .fs_i     (fs_q),
    .cin_i    (cin_q),
    .result_o (alu_res_d),
    .status_o (alu_status_d)
  );

  // Sequencer: handshake, operation latch, ALU/status capture and result pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      op_ready_q   <= 1'b1;
      sel_a_q      <= '0;
      sel_b_q      <= '0;
      sel_d_q      <= '0;
      fs_q         <= '0;
      cin_q        <= 1'b0;
      b_imm_q      <= 1'b0;
      imm_q        <= '0;
      reg_we_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      wb_sel_q     <= 1'b0;
      result_q     <= '0;
      res_data_q   <= '0;
      res_status_q <= '0;
      res_valid_q  <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (op_valid && op_ready_q) begin
            sel_a_q    <= op_sel_a;
            sel_b_q    <= op_sel_b;
            sel_d_q    <= op_sel_d;
            fs_q       <= op_fs;
            cin_q      <= op_cin;
            b_imm_q    <= op_b_imm;
            imm_q      <= op_imm;
            reg_we_q   <= op_reg_we;
            ram_we_q   <= op_ram_we;
            wb_sel_q   <= op_wb_sel;
            op_ready_q <= 1'b0;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q     <= alu_res_d;
          res_status_q <= alu_status_d;
          state_q      <= S_MEM;
        end
        S_MEM: begin
          // Result is published here so res_valid is high during WB
          res_data_q  <= wb_data_d;
          res_valid_q <= 1'b1;
          state_q     <= S_WB;
        end
        S_WB: begin
          op_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: begin
          op_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  // Register file: cleared on reset, written in WB; r0 is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (state_q == S_WB && reg_we_q && sel_d_q != '0) begin
      rf_q[sel_d_q] <= res_data_q;
    end
  end

  // Data RAM: no reset, store of reg[sel_b] during MEM
  always_ff @(posedge clk) begin
    if (state_q == S_MEM && ram_we_q) begin
      ram_q[ram_addr_d] <= rf_q[sel_b_q];
    end
  end

  assign op_ready   = op_ready_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_status = res_status_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_seq
//  Description : Directed self-checking bench for datapath_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_seq;

  localparam int DATA_W = 64;
  localparam int NREG   = 32;
  localparam int DEPTH  = 256;
  localparam int FS_W   = 5;

  localparam logic [4:0] F_PASS_A = 5'd0;
  localparam logic [4:0] F_PASS_B = 5'd1;
  localparam logic [4:0] F_ADD    = 5'd2;
  localparam logic [4:0] F_SUB    = 5'd3;
  localparam logic [4:0] F_NOT_A  = 5'd7;
  localparam logic [4:0] F_SHL    = 5'd8;
  localparam logic [4:0] F_SHR    = 5'd9;
  localparam logic [4:0] F_BAD    = 5'd10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [4:0]        op_sel_a = '0;
  logic [4:0]        op_sel_b = '0;
  logic [4:0]        op_sel_d = '0;
  logic [FS_W-1:0]   op_fs = '0;
  logic              op_cin = 1'b0;
  logic              op_b_imm = 1'b0;
  logic [DATA_W-1:0] op_imm = '0;
  logic              op_reg_we = 1'b0;
  logic              op_ram_we = 1'b0;
  logic              op_wb_sel = 1'b0;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [3:0]        res_status;

  int n_checks = 0;
  int n_errors = 0;

  datapath_seq #(
    .DATA_W    (DATA_W),
    .NREG      (NREG),
    .RAM_DEPTH (DEPTH),
    .FS_W      (FS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_sel_a   (op_sel_a),
    .op_sel_b   (op_sel_b),
    .op_sel_d   (op_sel_d),
    .op_fs      (op_fs),
    .op_cin     (op_cin),
    .op_b_imm   (op_b_imm),
    .op_imm     (op_imm),
    .op_reg_we  (op_reg_we),
    .op_ram_we  (op_ram_we),
    .op_wb_sel  (op_wb_sel),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_status (res_status)
  );

  always #5 clk = ~clk;

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Present fields (op_valid left to caller)
  task automatic set_op(input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] sd,
                        input logic [4:0] fs, input logic cin, input logic bimm,
                        input logic [63:0] imm, input logic rwe, input logic mwe,
                        input logic wbs);
    op_sel_a = sa; op_sel_b = sb; op_sel_d = sd; op_fs = fs; op_cin = cin;
    op_b_imm = bimm; op_imm = imm; op_reg_we = rwe; op_ram_we = mwe; op_wb_sel = wbs;
  endtask

  // Issue one operation and wait for its result; lat = negedges after transfer edge
  task automatic run_op(input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] sd,
                        input logic [4:0] fs, input logic cin, input logic bimm,
                        input logic [63:0] imm, input logic rwe, input logic mwe,
                        input logic wbs, output logic [63:0] data, output logic [3:0] st,
                        output int lat);
    for (int i = 0; i < 20 && op_ready !== 1'b1; i++) @(negedge clk);
    set_op(sa, sb, sd, fs, cin, bimm, imm, rwe, mwe, wbs);
    op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    data = res_data;
    st   = res_status;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (op_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", op_ready); end
    n_checks++;
    if (res_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
    n_checks++;
    if (res_data !== 64'h0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", res_data); end
    n_checks++;
    if (res_status !== 4'h0) begin n_errors++; $display("FAIL reset_status: got %b expected 0000", res_status); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_imm_add();
    logic [63:0] d; logic [3:0] s; int lat;
    run_op(5'd0, 5'd0, 5'd3, F_PASS_B, 1'b0, 1'b1, 64'd5, 1'b1, 1'b0, 1'b0, d, s, lat);
    n_checks++;
    if (lat !== 3) begin n_errors++; $display("FAIL imm_latency: got %0d expected 3", lat); end
    n_checks++;
    if (d !== 64'd5) begin n_errors++; $display("FAIL imm_data: got %h expected 5", d); end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || op_ready !== 1'b1)
      begin n_errors++; $display("FAIL pulse_then_ready: valid %b ready %b expected 0 1", res_valid, op_ready); end
    run_op(5'd3, 5'd3, 5'd4, F_ADD, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, d, s, lat);
    n_checks++;
    if (d !== 64'hA || s !== 4'b0000)
      begin n_errors++; $display("FAIL add_r3_r3: got %h/%b expected a/0000", d, s); end
  endtask

  task automatic test_flags();
    logic [63:0] d; logic [3:0] s; int lat;
    run_op(5'd0, 5'd0, 5'd1, F_PASS_B, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, d, s, lat);
    n_checks++;
    if (d !== 64'h7FFF_FFFF_FFFF_FFFF || s !== 4'b0000)
      begin n_errors++; $display("FAIL load_max: got %h/%b expected 7fffffffffffffff/0000", d, s); end
    run_op(5'd1, 5'd0, 5'd2, F_ADD, 1'b0, 1'b1, 64'd1, 1'b1, 1'b0, 1'b0, d, s, lat);
    n_checks++;
    if (d !== 64'h8000_0000_0000_0000 || s !== 4'b1010)
      begin n_errors++; $display("FAIL add_overflow: got %h/%b expected 8000000000000000/1010", d, s); end
    run_op(5'd0, 5'd0, 5'd0, F_SUB, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, d, s, lat);
    n_checks++;
    if (d !== 64'h0 || s !== 4'b0101)
      begin n_errors++; $display("FAIL sub_zero: got %h/%b expected 0/0101", d, s); end
    run_op(5'd0, 5'd0, 5'd0, F_NOT_A, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, d, s, lat);
    n_checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF || s !== 4'b0010)
      begin n_errors++; $display("FAIL not_r0: got %h/%b expected ffffffffffffffff/0010", d, s); end
    run_op(5'd3, 5'd0, 5'd0, F_SHL, 1'b0, 1'b1, 64'd66, 1'b0, 1'b0, 1'b0, d, s, lat);
    n_checks++;
    if (d !== 64'd20 || s !== 4'b0000)
      begin n_errors++; $display("FAIL shl_wrap_amt: got %h/%b expected 14/0000", d, s); end
    run_op(5'd1, 5'd0, 5'd0, F_SHR, 1'b0, 1'b1, 64'd60, 1'b0, 1'b0, 1'b0, d, s, lat);
    n_checks++;
    if (d !== 64'd7) begin n_errors++; $display("FAIL shr: got %h expected 7", d); end
    run_op(5'd3, 5'd0, 5'd0, F_BAD, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, d, s, lat);
    n_checks++;
    if (d !== 64'h0 || s !== 4'b0001)
      begin n_errors++; $display("FAIL bad_code: got %h/%b expected 0/0001", d, s); end
  endtask

  task automatic test_ram();
    logic [63:0] d; logic [3:0] s; int lat;
    run_op(5'd0, 5'd0, 5'd5, F_PASS_B, 1'b0, 1'b1, 64'h1FF, 1'b1, 1'b0, 1'b0, d, s, lat);
    run_op(5'd5, 5'd4, 5'd0, F_PASS_A, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, d, s, lat);
    n_checks++;
    if (d !== 64'h1FF) begin n_errors++; $display("FAIL store_result: got %h expected 1ff", d); end
    run_op(5'd0, 5'd0, 5'd0, F_PASS_B, 1'b0, 1'b1, 64'hFF, 1'b0, 1'b0, 1'b1, d, s, lat);
    n_checks++;
    if (d !== 64'hA) begin n_errors++; $display("FAIL load_wrap: got %h expected a", d); end
    run_op(5'd0, 5'd3, 5'd0, F_PASS_B, 1'b0, 1'b1, 64'hFF, 1'b0, 1'b1, 1'b1, d, s, lat);
    n_checks++;
    if (d !== 64'hA) begin n_errors++; $display("FAIL read_first: got %h expected a", d); end
    run_op(5'd0, 5'd0, 5'd0, F_PASS_B, 1'b0, 1'b1, 64'hFF, 1'b0, 1'b0, 1'b1, d, s, lat);
    n_checks++;
    if (d !== 64'd5) begin n_errors++; $display("FAIL load_after_store: got %h expected 5", d); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic [3:0] s; int lat;
    for (int i = 0; i < 20 && op_ready !== 1'b1; i++) @(negedge clk);
    // Store r1 to 0xFF; result all-ones sets N in EXEC
    set_op(5'd0, 5'd1, 5'd7, F_PASS_B, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (res_status !== 4'b0010) begin n_errors++; $display("FAIL mid_status_pre: got %b expected 0010", res_status); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (op_ready !== 1'b1 || res_valid !== 1'b0 || res_status !== 4'h0 || res_data !== 64'h0)
      begin n_errors++; $display("FAIL mid_reset: ready %b valid %b st %b data %h expected 1 0 0000 0",
                                 op_ready, res_valid, res_status, res_data); end
    @(negedge clk);
    rst = 1'b1;
    run_op(5'd0, 5'd0, 5'd0, F_PASS_B, 1'b0, 1'b1, 64'hFF, 1'b0, 1'b0, 1'b1, d, s, lat);
    n_checks++;
    if (d !== 64'd5) begin n_errors++; $display("FAIL ram_kept: got %h expected 5", d); end
    run_op(5'd7, 5'd0, 5'd0, F_PASS_A, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, d, s, lat);
    n_checks++;
    if (d !== 64'h0) begin n_errors++; $display("FAIL r7_cleared: got %h expected 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d; logic [3:0] s; int lat; int accepts;
    accepts = 0;
    for (int i = 0; i < 20 && op_ready !== 1'b1; i++) @(negedge clk);
    // Continuous request writing 0x55 into r0
    set_op(5'd0, 5'd0, 5'd0, F_PASS_B, 1'b0, 1'b1, 64'h55, 1'b1, 1'b0, 1'b0);
    op_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (op_ready !== (k % 4 == 0))
        begin n_errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, op_ready, (k % 4 == 0)); end
      n_checks++;
      if (res_valid !== (k % 4 == 3))
        begin n_errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", k, res_valid, (k % 4 == 3)); end
      if (op_ready === 1'b1) accepts++;
      @(negedge clk);
    end
    op_valid = 1'b0;
    n_checks++;
    if (accepts !== 4) begin n_errors++; $display("FAIL b2b_accepts: got %0d expected 4", accepts); end
    n_checks++;
    if (res_data !== 64'h55) begin n_errors++; $display("FAIL b2b_data: got %h expected 55", res_data); end
    run_op(5'd0, 5'd0, 5'd0, F_PASS_A, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, d, s, lat);
    n_checks++;
    if (d !== 64'h0 || s !== 4'b0001)
      begin n_errors++; $display("FAIL r0_zero: got %h/%b expected 0/0001", d, s); end
  endtask

  initial begin
    test_reset();
    test_imm_add();
    test_flags();
    test_ram();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
